// File: rtl/dmem_pkg.sv
// Shared constants, FSM state encodings and the alignment helper for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_OFF_W = 2;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // True when the enabled lanes do not fit the word/halfword/byte implied by the offset.
  function automatic logic lanes_misaligned(logic [WORD_BYTES-1:0] be, logic [BYTE_OFF_W-1:0] off);
    logic [WORD_BYTES-1:0] allowed;
    logic                  multi;
    multi = (be & 4'(be - 4'd1)) != 4'h0;
    if (be == 4'hF) begin
      allowed = (off == 2'd0) ? 4'hF : 4'h0;
    end else if (multi) begin
      allowed = off[0] ? 4'h0 : 4'(4'b0011 << off);
    end else begin
      allowed = 4'(4'b0001 << off);
    end
    return (be & ~allowed) != 4'h0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core load/store path (master) and the data memory (slave).
interface dmem_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_storage.sv
// DEPTH x 32-bit word array with byte-enable synchronous writes and a registered read port.
module dmem_storage
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en_i,
  input  logic                    rd_en_i,
  input  logic [IDX_W-1:0]        idx_i,
  input  logic [WORD_BYTES*8-1:0] wdata_i,
  input  logic [WORD_BYTES-1:0]   be_i,
  output logic [WORD_BYTES*8-1:0] rdata_o
);

  logic [WORD_BYTES*8-1:0] mem_q [DEPTH];
  logic [WORD_BYTES*8-1:0] rdata_q;

  // Array is deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (be_i[i]) begin
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Handshaked, wait-state-configurable data-memory responder for the core load/store path.
// Define DMEM_FAULT_EN to enable alignment/range fault checking with rsp_err reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [1:0]            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   be_q;
  logic                  load_ok_q;
  logic                  err_q;

  logic                  accept;
  logic                  access;
  logic                  fault;
  logic [DATA_W-1:0]     stor_rdata;

  assign accept = bus.req_valid && (state_q == StIdle);
  assign access = (state_q == StWait) && (cnt_q == '0);

`ifdef DMEM_FAULT_EN
  assign fault = lanes_misaligned(be_q, addr_q[BYTE_OFF_W-1:0]) ||
                 ({{BYTE_OFF_W{1'b0}}, addr_q[ADDR_W-1:BYTE_OFF_W]} >= ADDR_W'(DEPTH));
`else
  // Upper address bits wrap and the byte offset is ignored without fault checking.
  logic unused_addr;
  assign unused_addr = ^{addr_q[BYTE_OFF_W-1:0], addr_q[ADDR_W-1:IDX_W+BYTE_OFF_W]};
  assign fault       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StWait;
          cnt_d   = WAIT_CNT_W'(WAIT_STATES);
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      load_ok_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (access) begin
        load_ok_q <= !we_q && !fault;
        err_q     <= fault;
      end
    end
  end

  dmem_storage #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (access && we_q && !fault),
    .rd_en_i (access && !we_q && !fault),
    .idx_i   (addr_q[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (stor_rdata)
  );

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  // Store and fault responses return zero data.
  assign bus.rsp_rdata = load_ok_q ? stor_rdata : '0;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: WAIT_STATES=2 and WAIT_STATES=0 instances vs a word model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();
  dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  // Shared driver; sel picks which instance sees valid/ready and whose outputs are observed.
  logic        sel = 1'b0;
  logic        d_valid = 1'b0, d_we = 1'b0, d_rready = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;

  assign bus2.req_valid = d_valid & ~sel;
  assign bus0.req_valid = d_valid & sel;
  assign bus2.rsp_ready = d_rready & ~sel;
  assign bus0.rsp_ready = d_rready & sel;
  assign bus2.req_we    = d_we;
  assign bus0.req_we    = d_we;
  assign bus2.req_addr  = d_addr;
  assign bus0.req_addr  = d_addr;
  assign bus2.req_wdata = d_wdata;
  assign bus0.req_wdata = d_wdata;
  assign bus2.req_be    = d_be;
  assign bus0.req_be    = d_be;

  logic        m_req_ready, m_rsp_valid, m_err;
  logic [31:0] m_rdata;
  assign m_req_ready = sel ? bus0.req_ready : bus2.req_ready;
  assign m_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  assign m_err       = sel ? bus0.rsp_err   : bus2.rsp_err;
  assign m_rdata     = sel ? bus0.rsp_rdata : bus2.rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference memories: one word per index, absent entries read as zero.
  logic [31:0] mem2 [int unsigned];
  logic [31:0] mem0 [int unsigned];

`ifdef DMEM_FAULT_EN
  function automatic bit is_fault(input logic [31:0] addr, input logic [3:0] be);
    int unsigned off = addr % 4;
    bit mis;
    case ($countones(be))
      0:       mis = 1'b0;
      1:       mis = (be != 4'(1 << off));
      2:       mis = !((off % 2 == 0) && (be == 4'(3 << off)));
      4:       mis = (off != 0);
      default: mis = 1'b1;
    endcase
    return mis || ((addr >> 2) >= DEPTH);
  endfunction
`endif

  function automatic void model(input bit s, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rd, output bit err);
    int unsigned idx = (addr >> 2) % DEPTH;
    logic [31:0] w;
    err = 1'b0;
`ifdef DMEM_FAULT_EN
    err = is_fault(addr, be);
`endif
    if (s) w = mem0.exists(idx) ? mem0[idx] : 32'h0;
    else   w = mem2.exists(idx) ? mem2[idx] : 32'h0;
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        if (s) mem0[idx] = w;
        else   mem2[idx] = w;
      end else begin
        rd = w;
      end
    end
  endfunction

  task automatic start_req(input string name, input bit s, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output bit ok);
    int n = 0;
    sel = s; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_valid = 1'b1;
    #1;
    while (!m_req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    ok = m_req_ready;
    check({name, "/req_ready"}, m_req_ready, 1);
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input bit s);
    int n = 0;
    while (!m_rsp_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({name, "/latency"}, n, s ? 1 : 3);
  endtask

  task automatic txn(input string name, input bit s, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int stall,
                     output logic [31:0] rd, output bit err);
    logic [31:0] erd;
    bit eerr, ok;
    rd = '0; err = 1'b0;
    model(s, we, addr, wdata, be, erd, eerr);
    start_req(name, s, we, addr, wdata, be, ok);
    if (!ok) return;
    wait_rsp(name, s);
    if (!m_rsp_valid) return;
    rd = m_rdata; err = m_err;
    repeat (stall) begin
      @(posedge clk); #1;
      check({name, "/stall"}, {m_rsp_valid, m_req_ready, m_err, m_rdata}, {1'b1, 1'b0, err, rd});
    end
    d_rready = 1'b1;
    @(posedge clk); #1;
    d_rready = 1'b0;
    check({name, "/release"}, m_rsp_valid, 0);
    check({name, "/rdata"}, rd, erd);
    check({name, "/err"}, err, eerr);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd, erd;
    bit err, eerr, ok;

    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0};
`ifdef DMEM_FAULT_EN
    vecs[3] = '{1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 32'h20, 32'h0, 4'hF, 32'h11223344, 1'b0};
`else
    vecs[3] = '{1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0};
`endif
    vecs[5] = '{1'b1, 32'h10, 32'h12345678, 4'h0, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("reset/req_ready", {bus2.req_ready, bus0.req_ready}, 2'b11);
    check("reset/rsp_valid", {bus2.rsp_valid, bus0.rsp_valid}, 2'b00);
    check("reset/rsp_err", {bus2.rsp_err, bus0.rsp_err}, 2'b00);
    check("reset/rsp_rdata", {bus2.rsp_rdata, bus0.rsp_rdata}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      txn($sformatf("vec%0d", i), 1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
          i % 3, rd, err);
      check($sformatf("vec%0d/tbl_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d/tbl_err", i), err, vecs[i].exp_err);
    end

    // Reset one cycle after a store is accepted: the write must never land.
    start_req("rst_store", 1'b0, 1'b1, 32'h40, 32'h5555AAAA, 4'hF, ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid/rsp_valid", m_rsp_valid, 0);
    check("rst_mid/req_ready", m_req_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid/held", {m_rsp_valid, m_req_ready, m_rdata}, {1'b0, 1'b1, 32'h0});
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn("rst_load", 1'b0, 1'b0, 32'h40, 32'h0, 4'hF, 0, rd, err);
    check("rst_load/orig", rd, 32'h0);

    // Back-pressure with a second request held during the stall.
    model(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, erd, eerr);
    start_req("bp1", 1'b0, 1'b0, 32'h10, 32'h0, 4'hF, ok);
    wait_rsp("bp1", 1'b0);
    d_we = 1'b0; d_addr = 32'h20; d_be = 4'hF; d_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp1/stall", {m_rsp_valid, m_req_ready, m_rdata}, {1'b1, 1'b0, erd});
    end
    d_rready = 1'b1;
    @(posedge clk); #1;
    d_rready = 1'b0;
    check("bp1/handshake", {m_rsp_valid, m_req_ready}, 2'b01);
    @(posedge clk); #1;
    check("bp2/accepted", m_req_ready, 0);
    d_valid = 1'b0;
    model(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, erd, eerr);
    wait_rsp("bp2", 1'b0);
    check("bp2/rdata", m_rdata, erd);
    d_rready = 1'b1;
    @(posedge clk); #1;
    d_rready = 1'b0;

    // Zero wait states and address wrap on the second instance.
    txn("ws0_store", 1'b1, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 0, rd, err);
    txn("ws0_load", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1, rd, err);
`ifdef DMEM_FAULT_EN
    check("ws0_load/const", rd, 32'h0);
`else
    check("ws0_load/const", rd, 32'hCAFEF00D);
`endif

`ifdef DMEM_FAULT_EN
    txn("flt_mis", 1'b0, 1'b0, 32'h42, 32'h0, 4'hF, 0, rd, err);
    check("flt_mis/const", {err, rd}, {1'b1, 32'h0});
    txn("flt_w0", 1'b0, 1'b1, 32'h0, 32'h01020304, 4'hF, 0, rd, err);
    txn("flt_range", 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd, err);
    check("flt_range/const", err, 1);
    txn("flt_chk0", 1'b0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd, err);
    check("flt_chk0/const", rd, 32'h01020304);
`endif

    // Randomised traffic on both instances, including wrapped/out-of-range addresses.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      addr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 2)
           | 32'($urandom_range(0, 3));
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
          $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), rd, err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder (target) end of the processor data-memory bus: accepts load/store requests from the core's load/store path and returns read data or a write acknowledgement.
- Replaces the ideal zero-latency data memory with a handshaked, wait-state-configurable memory model.
- Lets the core be exercised against realistic multi-cycle memory before a cache or SRAM controller exists.

Parameters:
- ADDR_W, 32, byte-address width of req_addr.
- DATA_W, 32, data width; fixed at 32 (RV32 word).
- DEPTH, 1024, number of 32-bit words stored; power of two.
- WAIT_STATES, 2, extra cycles between request acceptance and response; 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, lane-aligned.
- req_be  in  DATA_W/8  byte enables for stores; ignored on loads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  DATA_W  load data; 0 for store responses.
- rsp_err  out  1  access fault; only driven when DMEM_FAULT_EN is defined, else tied 0.

Behaviour:
- Reset (async assert, sync release): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, req_ready=1. Memory contents are not cleared by reset; simulation initial value is 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture we/addr/wdata/be.
  - Load counter with WAIT_STATES.
  - Go to WAIT, or to ACCESS-then-RESP directly if WAIT_STATES==0.
- WAIT:
  - req_ready=0; decrement counter each cycle.
  - When counter reaches 0, perform the access on that edge and go to RESP.
- Access:
  - Word index = captured addr[ADDR_W-1:2] modulo DEPTH; addr[1:0] ignored; out-of-range wraps.
  - Store writes each byte lane i where be[i]=1.
  - Load registers the full word into rsp_rdata.
  - Access happens exactly once per request.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0 and return to IDLE.
  - The next request can be accepted no earlier than the cycle after the handshake.
- Latency: request accepted at edge T gives rsp_valid high after edge T+1+WAIT_STATES. With rsp_ready held high, throughput is one request per WAIT_STATES+3 cycles.
- rsp_ready held low: stall in RESP indefinitely with outputs frozen.
- req_valid while busy: ignored (req_ready=0); the core must hold the request.
- Store with be=0: no memory change; response still returned.
- Reset mid-operation:
  - A request not yet at its access edge performs no write.
  - A pending response is dropped; outputs return to reset values.

Optional Feature:
- Macro: DMEM_FAULT_EN.
- Defined:
  - A request is a fault if it is misaligned (word access with addr[1:0]!=0 when be=4'b1111, or be lanes outside the halfword/byte implied by addr[1:0]) or if addr[ADDR_W-1:2] >= DEPTH.
  - A faulting request performs no write, returns rsp_rdata=0 and rsp_err=1, with the same latency.
- Undefined: no checking, wrap-around addressing, rsp_err constant 0.

Decomposition:
- Package dmem_pkg: FSM state enum (IDLE, WAIT, RESP), WORD_BYTES=4, BYTE_OFF_W=2, WAIT counter width constant (4).
- One natural sub-module, dmem_storage:
  - Synchronous byte-enable write array of DEPTH×32 with a registered read port.
  - The responder FSM instantiates it and owns all handshake and counter logic.

Test Plan:
- Store then load, WAIT_STATES=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> rsp_valid 3 cycles after each acceptance; load rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte-enable merge: store 0x11223344 to 0x20, then store 0xAABBCCDD with be 4'b0101, then load 0x20 -> rsp_rdata=0x11BB33DD.
- Back-pressure: load with rsp_ready low for 5 cycles -> rsp_valid stays 1, rsp_rdata stable, req_ready 0; the second request is accepted only after the handshake.
- WAIT_STATES=0 and wrap: load accepted at T gives rsp_valid after T+1. With DEPTH=1024 and the feature off, store to 0x1000 then load 0x0 -> same data.
- Reset mid-operation: store to 0x40 accepted, assert rst_n=0 one cycle later, release, then load 0x40 -> original value (0); rsp_valid was 0 during reset.
- DMEM_FAULT_EN: load 0x42 with be 4'hF -> rsp_err=1, rsp_rdata=0. Store to word index 1024 -> rsp_err=1, and word 0 is unchanged.
